// File: rtl/atcbmc200_pkg.sv
// Shared AHB encodings and default-slave state type for the atcbmc200 matrix.
package atcbmc200_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DFLT_IDLE = 2'd0,
    DFLT_ERR1 = 2'd1,
    DFLT_ERR2 = 2'd2
  } dflt_state_e;

endpackage

// File: rtl/atcbmc200_dflt_slv.sv
// Default slave: answers unmapped transfers with a two-cycle AHB ERROR and
// keeps a saturating count of how many it has answered.
module atcbmc200_dflt_slv
  import atcbmc200_pkg::*;
#(
  parameter int ERRCNT_WIDTH = 8
) (
  input  logic                    hclk,
  input  logic                    hresetn,
  input  logic                    accept,
  input  logic                    unmapped,
  input  logic                    err_clr,
  output logic                    dflt_hready,
  output logic                    dflt_hresp,
  output dflt_state_e             state,
  output logic [ERRCNT_WIDTH-1:0] err_cnt
);

  dflt_state_e state_d;
  logic        err_inc;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= DFLT_IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    unique case (state)
      DFLT_IDLE: if (accept && unmapped) state_d = DFLT_ERR1;
      DFLT_ERR1: state_d = DFLT_ERR2;
      DFLT_ERR2: state_d = (accept && unmapped) ? DFLT_ERR1 : DFLT_IDLE;
      default:   state_d = DFLT_IDLE;
    endcase
  end

  always_comb begin
    dflt_hready = 1'b1;
    dflt_hresp  = HRESP_OKAY;
    unique case (state)
      DFLT_ERR1: begin
        dflt_hready = 1'b0;
        dflt_hresp  = HRESP_ERROR;
      end
      DFLT_ERR2: begin
        dflt_hready = 1'b1;
        dflt_hresp  = HRESP_ERROR;
      end
      default: ;
    endcase
  end

  // Every entry into ERR1 (from IDLE or ERR2) is one new unmapped transfer.
  assign err_inc = (state_d == DFLT_ERR1) && (state != DFLT_ERR1);

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)                       err_cnt <= '0;
    else if (err_clr)                   err_cnt <= '0;
    else if (err_inc && err_cnt != '1)  err_cnt <= err_cnt + ERRCNT_WIDTH'(1);
  end

endmodule

// File: rtl/atcbmc200_rspmux.sv
// Per-master data-phase response stage: registers the decoder select into a
// one-hot data-phase select and routes the chosen slave (or default slave) back.
module atcbmc200_rspmux
  import atcbmc200_pkg::*;
#(
  parameter int NSLV         = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ERRCNT_WIDTH = 8
) (
  input  logic                       hclk,
  input  logic                       hresetn,
  input  logic [NSLV-1:0]            sel,
  input  logic [1:0]                 htrans,
  input  logic [NSLV-1:0]            slv_hreadyout,
  input  logic [NSLV-1:0]            slv_hresp,
  input  logic [NSLV*DATA_WIDTH-1:0] slv_hrdata,
  input  logic                       err_clr,
  output logic                       hready,
  output logic                       hresp,
  output logic [DATA_WIDTH-1:0]      hrdata,
  output logic [NSLV-1:0]            dsel,
  output logic [ERRCNT_WIDTH-1:0]    err_cnt
);

  logic            valid;
  logic            accept;
  logic            unmapped;
  logic [NSLV-1:0] pick;
  dflt_state_e     dflt_state;
  logic            dflt_hready;
  logic            dflt_hresp;

  assign valid    = htrans[1];
  assign accept   = hready;
  assign unmapped = valid && (sel == '0);

  // Isolate the lowest set bit so overlapping decoder maps resolve to one slave.
  assign pick = sel & (~sel + NSLV'(1));

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn)    dsel <= '0;
    else if (accept) dsel <= valid ? pick : '0;
  end

  always_comb begin
    hready = dflt_hready;
    hresp  = dflt_hresp;
    hrdata = '0;
    if (dsel != '0 && dflt_state == DFLT_IDLE) begin
      hready = 1'b0;
      hresp  = HRESP_OKAY;
      for (int i = 0; i < NSLV; i++) begin
        if (dsel[i]) begin
          hready = hready | slv_hreadyout[i];
          hresp  = hresp | slv_hresp[i];
          hrdata = hrdata | slv_hrdata[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  atcbmc200_dflt_slv #(
    .ERRCNT_WIDTH (ERRCNT_WIDTH)
  ) u_dflt_slv (
    .hclk        (hclk),
    .hresetn     (hresetn),
    .accept      (accept),
    .unmapped    (unmapped),
    .err_clr     (err_clr),
    .dflt_hready (dflt_hready),
    .dflt_hresp  (dflt_hresp),
    .state       (dflt_state),
    .err_cnt     (err_cnt)
  );

endmodule

// File: tb/tb_atcbmc200_rspmux.sv
// Directed scoreboard bench for atcbmc200_rspmux (4 slaves, 32-bit data, 2-bit error counter).
module tb_atcbmc200_rspmux;

  localparam int NSLV = 4;
  localparam int DW   = 32;
  localparam int EW   = 2;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_BUSY   = 2'b01;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  localparam logic [31:0] D0 = 32'hCAFE_0000;
  localparam logic [31:0] D1 = 32'hCAFE_0001;
  localparam logic [31:0] D2 = 32'hCAFE_0002;

  logic               hclk;
  logic               hresetn;
  logic [NSLV-1:0]    sel;
  logic [1:0]         htrans;
  logic [NSLV-1:0]    slv_hreadyout;
  logic [NSLV-1:0]    slv_hresp;
  logic [NSLV*DW-1:0] slv_hrdata;
  logic               err_clr;
  logic               hready;
  logic               hresp;
  logic [DW-1:0]      hrdata;
  logic [NSLV-1:0]    dsel;
  logic [EW-1:0]      err_cnt;

  typedef struct {
    string         name;
    logic          hready;
    logic          hresp;
    logic [DW-1:0] hrdata;
    logic [3:0]    dsel;
    logic [EW-1:0] err_cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   vectors;
  int   miscompares;

  atcbmc200_rspmux #(
    .NSLV         (NSLV),
    .DATA_WIDTH   (DW),
    .ERRCNT_WIDTH (EW)
  ) dut (
    .hclk          (hclk),
    .hresetn       (hresetn),
    .sel           (sel),
    .htrans        (htrans),
    .slv_hreadyout (slv_hreadyout),
    .slv_hresp     (slv_hresp),
    .slv_hrdata    (slv_hrdata),
    .err_clr       (err_clr),
    .hready        (hready),
    .hresp         (hresp),
    .hrdata        (hrdata),
    .dsel          (dsel),
    .err_cnt       (err_cnt)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check_output(input exp_t e);
    vectors++;
    if (hready !== e.hready || hresp !== e.hresp || hrdata !== e.hrdata ||
        dsel !== e.dsel || err_cnt !== e.err_cnt) begin
      miscompares++;
      $display("[TB] FAIL %s: got hready=%b hresp=%b hrdata=%h dsel=%b err_cnt=%0d, want hready=%b hresp=%b hrdata=%h dsel=%b err_cnt=%0d",
               e.name, hready, hresp, hrdata, dsel, err_cnt,
               e.hready, e.hresp, e.hrdata, e.dsel, e.err_cnt);
    end
  endtask

  // Outputs settle after the negedge drive; sample them just before the next posedge.
  always @(negedge hclk) begin
    #4;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check_output(mon_e);
    end
  end

  task automatic apply_stimulus(input string nm, input logic rst, input logic [3:0] s,
                                input logic [1:0] t, input logic [3:0] rdy,
                                input logic [3:0] rsp, input logic clr,
                                input logic e_rdy, input logic e_rsp,
                                input logic [DW-1:0] e_data, input logic [3:0] e_dsel,
                                input logic [EW-1:0] e_cnt);
    exp_t e;
    @(negedge hclk);
    hresetn       = rst;
    sel           = s;
    htrans        = t;
    slv_hreadyout = rdy;
    slv_hresp     = rsp;
    err_clr       = clr;
    e.name    = nm;
    e.hready  = e_rdy;
    e.hresp   = e_rsp;
    e.hrdata  = e_data;
    e.dsel    = e_dsel;
    e.err_cnt = e_cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    hresetn       = 1'b0;
    sel           = '0;
    htrans        = T_IDLE;
    slv_hreadyout = '1;
    slv_hresp     = '0;
    err_clr       = 1'b0;
    slv_hrdata    = {32'hCAFE_0003, D2, D1, D0};

    apply_stimulus("in_reset", 1'b0, 4'b0000, T_IDLE, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, '0, 4'b0000, 2'd0);
    for (int i = 0; i < 10; i++)
      apply_stimulus("post_reset_idle", 1'b1, 4'b0000, T_IDLE, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, '0, 4'b0000, 2'd0);

    // Mapped NONSEQ to slave 2 with two wait states.
    apply_stimulus("map_addr",   1'b1, 4'b0100, T_NONSEQ, 4'hF,    4'h0, 1'b0, 1'b1, 1'b0, '0, 4'b0000, 2'd0);
    apply_stimulus("map_wait1",  1'b1, 4'b0000, T_IDLE,   4'b1011, 4'h0, 1'b0, 1'b0, 1'b0, D2, 4'b0100, 2'd0);
    apply_stimulus("map_wait2",  1'b1, 4'b0001, T_NONSEQ, 4'b1011, 4'h0, 1'b0, 1'b0, 1'b0, D2, 4'b0100, 2'd0);
    apply_stimulus("map_done",   1'b1, 4'b0000, T_IDLE,   4'hF,    4'h0, 1'b0, 1'b1, 1'b0, D2, 4'b0100, 2'd0);

    // Unmapped NONSEQ, then unmapped SEQ presented during ERR2.
    apply_stimulus("unm_addr",   1'b1, 4'b0000, T_NONSEQ, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, '0, 4'b0000, 2'd0);
    apply_stimulus("unm_err1",   1'b1, 4'b0000, T_IDLE,   4'hF, 4'h0, 1'b0, 1'b0, 1'b1, '0, 4'b0000, 2'd1);
    apply_stimulus("unm_err2",   1'b1, 4'b0000, T_SEQ,    4'hF, 4'h0, 1'b0, 1'b1, 1'b1, '0, 4'b0000, 2'd1);
    apply_stimulus("unm2_err1",  1'b1, 4'b0000, T_IDLE,   4'hF, 4'h0, 1'b0, 1'b0, 1'b1, '0, 4'b0000, 2'd2);
    apply_stimulus("unm2_err2",  1'b1, 4'b0000, T_IDLE,   4'hF, 4'h0, 1'b0, 1'b1, 1'b1, '0, 4'b0000, 2'd2);

    // Overlapping select resolves to slave 1; its ERROR passes straight through.
    apply_stimulus("ovl_addr",   1'b1, 4'b1010, T_NONSEQ, 4'hF, 4'h0,    1'b0, 1'b1, 1'b0, '0, 4'b0000, 2'd2);
    apply_stimulus("ovl_data",   1'b1, 4'b1000, T_BUSY,   4'hF, 4'b0010, 1'b0, 1'b1, 1'b1, D1, 4'b0010, 2'd2);
    apply_stimulus("busy_okay",  1'b1, 4'b1000, T_IDLE,   4'hF, 4'h0,    1'b0, 1'b1, 1'b0, '0, 4'b0000, 2'd2);

    // Chain of unmapped transfers drives the 2-bit counter into saturation.
    apply_stimulus("sat_a",      1'b1, 4'b0000, T_NONSEQ, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, '0, 4'b0000, 2'd2);
    apply_stimulus("sat_a_e1",   1'b1, 4'b0000, T_IDLE,   4'hF, 4'h0, 1'b0, 1'b0, 1'b1, '0, 4'b0000, 2'd3);
    apply_stimulus("sat_b",      1'b1, 4'b0000, T_NONSEQ, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, '0, 4'b0000, 2'd3);
    apply_stimulus("sat_b_e1",   1'b1, 4'b0000, T_IDLE,   4'hF, 4'h0, 1'b0, 1'b0, 1'b1, '0, 4'b0000, 2'd3);
    apply_stimulus("sat_c",      1'b1, 4'b0000, T_NONSEQ, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, '0, 4'b0000, 2'd3);
    apply_stimulus("sat_c_e1",   1'b1, 4'b0000, T_IDLE,   4'hF, 4'h0, 1'b0, 1'b0, 1'b1, '0, 4'b0000, 2'd3);
    apply_stimulus("sat_d",      1'b1, 4'b0000, T_NONSEQ, 4'hF, 4'h0, 1'b0, 1'b1, 1'b1, '0, 4'b0000, 2'd3);
    apply_stimulus("sat_d_e1",   1'b1, 4'b0000, T_IDLE,   4'hF, 4'h0, 1'b0, 1'b0, 1'b1, '0, 4'b0000, 2'd3);

    // Clear wins over the increment of a new ERR1 entry; master then cancels in ERR2.
    apply_stimulus("clr_enter",  1'b1, 4'b0000, T_NONSEQ, 4'hF, 4'h0, 1'b1, 1'b1, 1'b1, '0, 4'b0000, 2'd3);
    apply_stimulus("clr_err1",   1'b1, 4'b0000, T_IDLE,   4'hF, 4'h0, 1'b0, 1'b0, 1'b1, '0, 4'b0000, 2'd0);
    apply_stimulus("cancel_e2",  1'b1, 4'b0000, T_IDLE,   4'hF, 4'h0, 1'b0, 1'b1, 1'b1, '0, 4'b0000, 2'd0);

    // Async reset in the middle of ERR1.
    apply_stimulus("pre_rst",    1'b1, 4'b0000, T_NONSEQ, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, '0, 4'b0000, 2'd0);
    apply_stimulus("rst_in_err1",1'b0, 4'b0000, T_IDLE,   4'hF, 4'h0, 1'b0, 1'b1, 1'b0, '0, 4'b0000, 2'd0);
    apply_stimulus("rst_hold",   1'b0, 4'b0001, T_NONSEQ, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, '0, 4'b0000, 2'd0);

    // After release, a mapped NONSEQ to slave 0 completes normally.
    apply_stimulus("s0_addr",    1'b1, 4'b0001, T_NONSEQ, 4'hF, 4'h0, 1'b0, 1'b1, 1'b0, '0, 4'b0000, 2'd0);
    apply_stimulus("s0_data",    1'b1, 4'b0000, T_IDLE,   4'hF, 4'h0, 1'b0, 1'b1, 1'b0, D0, 4'b0001, 2'd0);
    apply_stimulus("s0_after",   1'b1, 4'b0000, T_IDLE,   4'hF, 4'h0, 1'b0, 1'b1, 1'b0, '0, 4'b0000, 2'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge hclk);
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending vectors, want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
